instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 218 +++++++++++++++++++++
 tb/tb_instr_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front end. It issues one word-aligned read at a time to
// instruction memory and buffers the returned words with their PCs in a
// 2-entry FIFO for the decode stage. A taken branch/jump (redirect) flushes
// the buffer and restarts fetching at the new target. A response to a request
// that is still in flight when a redirect arrives is dropped.
//
// Parameters:
//   RESET_PC     first fetch address after reset (bits [1:0] must be 0)
//
// Ports:
//   clk          single clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   imem_req     read request to instruction memory
//   imem_addr    fetch address, valid while imem_req=1
//   imem_ack     memory response strobe (transfer when imem_req & imem_ack)
//   imem_rdata   fetched instruction word
//   instr_valid  instruction/instr_pc hold a valid entry (FIFO non-empty)
//   instr_ready  consumer accepts the presented entry
//   instruction  FIFO head word (0 while instr_valid=0)
//   instr_pc     FIFO head address (0 while instr_valid=0)
//   redirect     branch/jump taken: flush and restart fetch
//   redirect_pc  new fetch address, bits [1:0] ignored
//
// Optional build macro FETCH_STATS_EN adds:
//   fetch_count  32-bit count of delivered instructions (wraps)
//   flush_count  16-bit count of redirects (wraps)
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // fetch_pc is the address of the outstanding request while in REQ, and the
  // next address to request otherwise (the redirect target while in DISCARD).
  // req_addr is kept separately so imem_addr stays put during DISCARD.
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_next;
  logic [31:0] req_addr;
  logic        issue;

  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;

  logic        ack_in_req;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc_aligned;

  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

  assign imem_req    = (state != IDLE);
  assign imem_addr   = req_addr;
  assign instr_valid = (count != 2'd0);
  assign instruction = instr_valid ? fifo_instr[rd_ptr] : 32'h0000_0000;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0000_0000;

  // A redirect overrides both push and pop in the same cycle.
  assign ack_in_req = (state == REQ) && imem_ack;
  assign push       = ack_in_req && !redirect;
  assign pop        = instr_valid && instr_ready && !redirect;

  // FIFO occupancy after this edge; a new request is only launched when the
  // buffer will still have room for its response, so the FIFO cannot overflow.
  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  // Next-state and fetch-PC logic. issue marks an edge that launches a new
  // request; its address is fetch_pc_next.
  always_comb begin
    state_next    = state;
    issue         = 1'b0;
    fetch_pc_next = fetch_pc;

    if (redirect) begin
      fetch_pc_next = redirect_pc_aligned;
    end else if (ack_in_req) begin
      fetch_pc_next = fetch_pc + 32'd4;
    end

    case (state)
      IDLE: begin
        if (count_next < 2'd2) begin
          state_next = REQ;
          issue      = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (count_next < 2'd2) begin
            state_next = REQ;
            issue      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (redirect) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        // The dropped response completes here; a redirect on the same edge
        // just supplies the new target, which fetch_pc_next already holds.
        if (imem_ack) begin
          if (count_next < 2'd2) begin
            state_next = REQ;
            issue      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (issue) begin
        req_addr <= fetch_pc_next;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      count <= count_next;
      if (redirect) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
      end
    end
  end

  // FIFO storage needs no reset: the outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= req_addr;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'd0;
      flush_count <= 16'd0;
    end else begin
      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Two instances of instr_fetch share the stimulus: u_dut (RESET_PC=0) is
// followed every cycle by a queue-based reference model, and u_dut_hi
// (RESET_PC=FFFF_FFF8) is pinned with literal address-wrap expectations.
// Define FETCH_STATS_EN for both files to include the statistics checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic [31:0] imem_rdata_hi;

  logic        imem_req,    imem_req_hi;
  logic [31:0] imem_addr,   imem_addr_hi;
  logic        instr_valid, instr_valid_hi;
  logic [31:0] instruction, instruction_hi;
  logic [31:0] instr_pc,    instr_pc_hi;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, fetch_count_hi;
  logic [15:0] flush_count, flush_count_hi;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req_hi),
    .imem_addr   (imem_addr_hi),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata_hi),
    .instr_valid (instr_valid_hi),
    .instr_ready (instr_ready),
    .instruction (instruction_hi),
    .instr_pc    (instr_pc_hi),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count_hi),
    .flush_count (flush_count_hi)
`endif
  );

  // Memory contents: a fixed scramble of the address so every word differs.
  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model for u_dut. The buffer is a plain queue; a request is
  // launched whenever none is in flight and the queue will hold fewer than
  // two words. next_pc is advanced when a request is launched.
  // ------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      m_q[$];
  bit          m_busy;
  bit          m_drop;
  logic [31:0] m_cur;
  logic [31:0] m_next;
  logic [31:0] m_fetch;
  logic [15:0] m_flush;

  task automatic model_clear();
    m_q.delete();
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_cur   = 32'h0;
    m_next  = 32'h0;
    m_fetch = 32'h0;
    m_flush = 16'h0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else begin
      bit     took;
      entry_t e;
      took = (m_q.size() != 0) && instr_ready;
      if (took && !redirect) begin
        void'(m_q.pop_front());
        m_fetch = m_fetch + 32'd1;
      end
      if (m_busy && imem_ack) begin
        if (!m_drop && !redirect) begin
          e.pc   = m_cur;
          e.word = rdata_for(m_cur);
          m_q.push_back(e);
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
      if (redirect) begin
        m_q.delete();
        m_next  = {redirect_pc[31:2], 2'b00};
        m_flush = m_flush + 16'd1;
        if (m_busy) m_drop = 1'b1;
      end
      if (!m_busy && m_q.size() < 2) begin
        m_busy = 1'b1;
        m_cur  = m_next;
        m_next = m_next + 32'd4;
      end
    end
  end

  // Compare process: u_dut against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model imem_req", {31'b0, imem_req}, {31'b0, m_busy});
      if (m_busy) checkOutput("model imem_addr", imem_addr, m_cur);
      checkOutput("model instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        checkOutput("model instr_pc", instr_pc, m_q[0].pc);
        checkOutput("model instruction", instruction, m_q[0].word);
      end
`ifdef FETCH_STATS_EN
      checkOutput("model fetch_count", fetch_count, m_fetch);
      checkOutput("model flush_count", {16'b0, flush_count}, {16'b0, m_flush});
`endif
    end
  end

  // Drive one cycle of inputs, let the edge happen, then present the memory
  // word for whatever address each instance now requests.
  task automatic applyStimulus(input logic ack, input logic rdy,
                               input logic redir, input logic [31:0] rpc);
    imem_ack    = ack;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    #2;
    imem_rdata    = rdata_for(imem_addr);
    imem_rdata_hi = rdata_for(imem_addr_hi);
  endtask

  task automatic doReset();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    reset       = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset         = 1'b0;
    imem_rdata    = rdata_for(imem_addr);
    imem_rdata_hi = rdata_for(imem_addr_hi);
  endtask

  initial begin
    model_clear();
    reset         = 1'b1;
    imem_ack      = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    imem_rdata    = 32'h0;
    imem_rdata_hi = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;

    // Reset values
    checkOutput("rst imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst imem_addr", imem_addr, 32'h0);
    checkOutput("rst instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst instruction", instruction, 32'h0);
    checkOutput("rst instr_pc", instr_pc, 32'h0);
    checkOutput("rst hi imem_addr", imem_addr_hi, 32'hFFFF_FFF8);
    reset         = 1'b0;
    imem_rdata    = rdata_for(imem_addr);
    imem_rdata_hi = rdata_for(imem_addr_hi);

    // Streaming with ack and ready every cycle, plus address wrap on u_dut_hi
    $display("[TB] streaming fetch");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("A1 imem_req", {31'b0, imem_req}, 32'd1);
    checkOutput("A1 imem_addr", imem_addr, 32'h0);
    checkOutput("A1 hi imem_addr", imem_addr_hi, 32'hFFFF_FFF8);
    checkOutput("A1 instr_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("A2 imem_addr", imem_addr, 32'h4);
    checkOutput("A2 instr_pc", instr_pc, 32'h0);
    checkOutput("A2 instruction", instruction, rdata_for(32'h0));
    checkOutput("A2 hi imem_addr", imem_addr_hi, 32'hFFFF_FFFC);
    checkOutput("A2 hi instr_pc", instr_pc_hi, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("A3 imem_addr", imem_addr, 32'h8);
    checkOutput("A3 instr_pc", instr_pc, 32'h4);
    checkOutput("A3 hi imem_addr", imem_addr_hi, 32'h0);
    checkOutput("A3 hi instr_pc", instr_pc_hi, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("A4 instr_pc", instr_pc, 32'h8);
    checkOutput("A4 instruction", instruction, rdata_for(32'h8));
    checkOutput("A4 hi instr_pc", instr_pc_hi, 32'h0);
    checkOutput("A4 hi instruction", instruction_hi, rdata_for(32'h0));
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Consumer stall: buffer fills to two, then drains in order
    $display("[TB] consumer stall");
    doReset();
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("B stall instr_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("B stall instr_pc", instr_pc, 32'h0);
    checkOutput("B stall instruction", instruction, rdata_for(32'h0));
    checkOutput("B stall imem_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("B drain1 instr_pc", instr_pc, 32'h4);
    checkOutput("B drain1 imem_addr", imem_addr, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("B drain2 instr_pc", instr_pc, 32'h8);

    // Redirect while a request is pending without ack
    $display("[TB] redirect with request pending");
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    checkOutput("C redir instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("C redir imem_addr", imem_addr, 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("C hold imem_addr", imem_addr, 32'h8);
    checkOutput("C hold imem_req", {31'b0, imem_req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("C drop instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("C new imem_addr", imem_addr, 32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("C new instr_pc", instr_pc, 32'h0000_0100);

    // Redirect coincident with ack and pop
    $display("[TB] redirect with ack and pop");
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    checkOutput("D instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("D imem_addr", imem_addr, 32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("D instr_pc", instr_pc, 32'h0000_0100);
    checkOutput("D instruction", instruction, rdata_for(32'h0000_0100));

    // Second redirect while discarding retargets the fetch
    $display("[TB] redirect during discard");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0050);
    checkOutput("E discard imem_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0077);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("E retarget imem_addr", imem_addr, 32'h0000_0074);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("E retarget instr_pc", instr_pc, 32'h0000_0074);

    // Handshake/redirect counting, then asynchronous reset mid-burst
    $display("[TB] counters and async reset");
    doReset();
    repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200);
`ifdef FETCH_STATS_EN
    checkOutput("F fetch_count", fetch_count, 32'd5);
    checkOutput("F flush_count", {16'b0, flush_count}, 32'd2);
`endif
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("F async imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("F async instr_valid", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_STATS_EN
    checkOutput("F async fetch_count", fetch_count, 32'd0);
    checkOutput("F async flush_count", {16'b0, flush_count}, 32'd0);
`endif
    #1;
    reset         = 1'b0;
    imem_rdata    = rdata_for(imem_addr);
    imem_rdata_hi = rdata_for(imem_addr_hi);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("F restart imem_addr", imem_addr, 32'h0);
    checkOutput("F restart instr_valid", {31'b0, instr_valid}, 32'd0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
